conv1d_core_mc: RTL and testbench

Parametrised multi-channel 1D convolution core, successor to the fixed 4-channel, 32-bit computing core.
- Loads a K-tap signed kernel once through a valid/ready port.
- Streams CH parallel sample channels through per-channel sliding windows.
- Emits one registered convolution result per channel per accepted sample, with backpressure, frame delimiting and a done pulse.
- Sits between the input sample buffers and the output writer in the convolution datapath.

---
 rtl/conv_pkg.sv | 38 +++
 rtl/conv_channel.sv | 80 ++++++++
 rtl/conv1d_core_mc.sv | 160 ++++++++++++++++
 tb/tb_conv1d_core_mc.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the multi-channel 1D convolution core.
// Contents:
//   state_e     - control FSM states (kernel load, window fill, steady run)
//   MaxSumW     - widest full-precision sum the saturation helper handles
//   sum_w()     - full-precision sum width: 2*data_w + clog2(k)
//   cnt_w()     - width of the tap and sample counters for a k-tap kernel
//   sat_or_wrap - clamps a full-precision sum to acc_w signed bits, or passes
//                 it through so the caller's truncation wraps
package conv_pkg;

  typedef enum logic [1:0] {StLoadKer, StFill, StRun} state_e;

  localparam int unsigned MaxSumW = 128;

  function automatic int unsigned sum_w(int unsigned data_w, int unsigned k);
    return 2 * data_w + $clog2(k);
  endfunction

  // Both counters only ever need to reach k-1.
  function automatic int unsigned cnt_w(int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  function automatic logic signed [MaxSumW-1:0] sat_or_wrap(
    logic signed [MaxSumW-1:0] sum,
    int unsigned               acc_w,
    bit                        sat
  );
    logic signed [MaxSumW-1:0] hi, lo;
    hi = (MaxSumW'(1) << (acc_w - 1)) - MaxSumW'(1);
    lo = ~hi;
    if (!sat)     return sum;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/conv_channel.sv
// One convolution channel: sliding window, K signed multipliers (stage 1
// register), adder tree and output register (stage 2).
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   clr_i           - clear the window (end of frame)
//   shift_i         - accepted sample: shift x_i into the window
//   prod_en_i       - load the product register (sample produces a result)
//   sum_en_i        - load the output register from the products
//   taps_i          - K signed taps, tap j at [j*DATA_W +: DATA_W]
//   x_i             - newest sample of this channel
//   y_o             - registered result
// Build option: CONV_SATURATE_EN clamps the result instead of wrapping.
module conv_channel
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K      = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic                prod_en_i,
  input  logic                sum_en_i,
  input  logic [K*DATA_W-1:0] taps_i,
  input  logic [DATA_W-1:0]   x_i,
  output logic [ACC_W-1:0]    y_o
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned SumW  = sum_w(DATA_W, K);
`ifdef CONV_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  // Window holds the K-1 previous samples; the newest comes straight from x_i.
  logic        [DATA_W-1:0] win_q  [K-1];
  logic signed [DATA_W-1:0] smp    [K];
  logic signed [ProdW-1:0]  prod_d [K];
  logic signed [ProdW-1:0]  prod_q [K];
  logic signed [SumW-1:0]   sum;
  logic        [ACC_W-1:0]  acc_d, acc_q;

  always_comb begin
    smp[0] = x_i;
    for (int j = 1; j < K; j++) smp[j] = win_q[j-1];
    for (int j = 0; j < K; j++) begin
      prod_d[j] = ProdW'(smp[j]) * ProdW'($signed(taps_i[j*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < K; j++) sum = sum + SumW'(prod_q[j]);
    acc_d = ACC_W'(sat_or_wrap(MaxSumW'(sum), ACC_W, SatEn));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int j = 0; j < K - 1; j++) win_q[j] <= '0;
      for (int j = 0; j < K; j++) prod_q[j] <= '0;
      acc_q <= '0;
    end else begin
      if (clr_i) begin
        for (int j = 0; j < K - 1; j++) win_q[j] <= '0;
      end else if (shift_i) begin
        win_q[0] <= x_i;
        for (int j = 1; j < K - 1; j++) win_q[j] <= win_q[j-1];
      end
      if (prod_en_i) prod_q <= prod_d;
      if (sum_en_i)  acc_q  <= acc_d;
    end
  end

  assign y_o = acc_q;

endmodule

// File: rtl/conv1d_core_mc.sv
// Multi-channel 1D convolution core. Loads K signed taps, then streams CH
// channels through per-channel windows, producing one result vector per
// accepted sample once the window is full. Two-stage pipeline (products,
// sum) that freezes while the output is stalled.
// Ports:
//   clk_i, reset_i                    - clock, synchronous active-high reset
//   ker_valid_i/ker_data_i/ker_ready_o - kernel tap load handshake
//   keep_kernel_i                     - at frame end: 1 keep taps, 0 reload
//   in_valid_i/in_data_i/in_last_i/in_ready_o - sample vector stream
//   out_valid_o/out_data_o/out_last_o/out_ready_i - result vector stream
//   done_o                            - one-cycle end-of-frame pulse
// Build option: CONV_SATURATE_EN clamps results instead of wrapping.
module conv1d_core_mc
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K      = 4,
  parameter int unsigned CH     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ker_valid_i,
  input  logic [DATA_W-1:0]    ker_data_i,
  output logic                 ker_ready_o,
  input  logic                 keep_kernel_i,
  input  logic                 in_valid_i,
  input  logic [CH*DATA_W-1:0] in_data_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic [CH*ACC_W-1:0]  out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic                 done_o
);

  localparam int unsigned CntW = cnt_w(K);

  state_e              state_q, state_d;
  logic [CntW-1:0]     tap_cnt_q, tap_cnt_d;
  logic [CntW-1:0]     smp_cnt_q, smp_cnt_d;
  logic [K*DATA_W-1:0] taps_q;
  logic                drain_q, drain_d;
  logic                done_q, done_d;
  logic                v1_q, last1_q, out_valid_q, out_last_q;
  logic                stall, adv, run, ker_fire, in_fire, out_fire;

  assign stall    = out_valid_q & ~out_ready_i;
  assign adv      = ~stall;
  assign run      = (state_q == StRun);
  assign ker_fire = ker_valid_i & ker_ready_o;
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_q & out_ready_i;

  // Readies are gated by reset so every output is 0 while reset is held.
  // Input is refused while the last result drains and on the done cycle.
  assign ker_ready_o = (state_q == StLoadKer) & ~reset_i;
  assign in_ready_o  = ((state_q == StFill) | run) & ~stall & ~drain_q & ~done_q & ~reset_i;

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    smp_cnt_d = smp_cnt_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    case (state_q)
      StLoadKer: begin
        if (ker_fire) begin
          if (tap_cnt_q == CntW'(K - 1)) begin
            tap_cnt_d = '0;
            state_d   = StFill;
          end else begin
            tap_cnt_d = tap_cnt_q + CntW'(1);
          end
        end
      end
      StFill: begin
        if (in_fire) begin
          if (in_last_i) begin
            done_d = 1'b1;  // frame shorter than K: no results
          end else if (smp_cnt_q == CntW'(K - 2)) begin
            smp_cnt_d = '0;
            state_d   = StRun;
          end else begin
            smp_cnt_d = smp_cnt_q + CntW'(1);
          end
        end
      end
      StRun: begin
        if (in_fire && in_last_i) drain_d = 1'b1;
        if (out_fire && out_last_q) begin
          drain_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StLoadKer;
    endcase
    // keep_kernel_i is sampled on the done cycle.
    if (done_q) begin
      state_d   = keep_kernel_i ? StFill : StLoadKer;
      tap_cnt_d = '0;
      smp_cnt_d = '0;
      drain_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StLoadKer;
      tap_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      taps_q      <= '0;
      drain_q     <= 1'b0;
      done_q      <= 1'b0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      for (int j = 0; j < K; j++) begin
        if (ker_fire && tap_cnt_q == CntW'(j)) taps_q[j*DATA_W +: DATA_W] <= ker_data_i;
      end
      if (adv) begin
        v1_q        <= in_fire & run;
        last1_q     <= in_fire & run & in_last_i;
        out_valid_q <= v1_q;
        out_last_q  <= v1_q & last1_q;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    conv_channel #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .K      (K)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (done_q),
      .shift_i   (in_fire),
      .prod_en_i (in_fire & run),
      .sum_en_i  (adv & v1_q),
      .taps_i    (taps_q),
      .x_i       (in_data_i[c*DATA_W +: DATA_W]),
      .y_o       (out_data_o[c*ACC_W +: ACC_W])
    );
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_conv1d_core_mc.sv
module tb_conv1d_core_mc;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned K      = 4;
  localparam int unsigned CH     = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ker_valid;
  logic [DATA_W-1:0]    ker_data;
  logic                 ker_ready;
  logic                 keep_kernel;
  logic                 in_valid;
  logic [CH*DATA_W-1:0] in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic [CH*ACC_W-1:0]  out_data;
  logic                 out_last;
  logic                 out_ready;
  logic                 done;

  always #5 clk = ~clk;

  conv1d_core_mc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .K      (K),
    .CH     (CH)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .ker_valid_i   (ker_valid),
    .ker_data_i    (ker_data),
    .ker_ready_o   (ker_ready),
    .keep_kernel_i (keep_kernel),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .in_ready_o    (in_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_last_o    (out_last),
    .out_ready_i   (out_ready),
    .done_o        (done)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CH*ACC_W-1:0] d;
    logic                last;
  } exp_t;

  exp_t                     exp_q[$];
  logic [CH*DATA_W-1:0]     hist_q[$];  // samples of the current frame
  logic signed [DATA_W-1:0] mtaps[K];
  int                       exp_done  = 0;
  int                       seen_done = 0;
  int                       rdy_mode  = 0;  // 0 always ready, 1 random, 2 hold low

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Result of a full-precision sum as the output port should show it.
  function automatic logic [ACC_W-1:0] ref_result(logic signed [127:0] s);
`ifdef CONV_SATURATE_EN
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (ACC_W - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    return s[ACC_W-1:0];
  endfunction

  // y_c[n] = sum_j w[j] * x_c[n-j], only once K samples of the frame exist.
  function automatic void model_accept(logic [CH*DATA_W-1:0] d, logic last);
    int                       n;
    exp_t                     e;
    logic signed [127:0]      s;
    logic [CH*DATA_W-1:0]     v;
    logic signed [DATA_W-1:0] xs;
    hist_q.push_back(d);
    n = hist_q.size();
    if (n >= int'(K)) begin
      e.d    = '0;
      e.last = last;
      for (int c = 0; c < int'(CH); c++) begin
        s = '0;
        for (int j = 0; j < int'(K); j++) begin
          v  = hist_q[n-1-j];
          xs = v[c*DATA_W +: DATA_W];
          s  = s + 128'(mtaps[j]) * 128'(xs);
        end
        e.d[c*ACC_W +: ACC_W] = ref_result(s);
      end
      exp_q.push_back(e);
    end
    if (last) begin
      exp_done++;
      hist_q.delete();
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, stall stability, done counting.
  logic                prev_stall = 1'b0;
  logic [CH*ACC_W-1:0] prev_d;
  logic                prev_l;
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (done) seen_done++;
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, prev_d);
        check("stall_last_held", out_last, prev_l);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready_low", in_ready, 0);
        prev_stall = 1'b1;
        prev_d     = out_data;
        prev_l     = out_last;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.last);
        end
      end
    end
  end

  task automatic load_kernel(input logic [K*DATA_W-1:0] t);
    int g;
    for (int j = 0; j < int'(K); j++) begin
      g         = 0;
      ker_valid = 1'b1;
      ker_data  = t[j*DATA_W +: DATA_W];
      @(negedge clk);
      while (!ker_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("ker_handshake", ker_ready, 1);
      mtaps[j] = t[j*DATA_W +: DATA_W];
      @(posedge clk);
      #1;
    end
    ker_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [CH*DATA_W-1:0] d, input logic last);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("in_handshake", in_ready, 1);
    if (in_ready) model_accept(d, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    bit got;
    g   = 0;
    got = 0;
    while (!got && g < 400) begin
      @(negedge clk);
      if (done) got = 1;
      g++;
    end
    check(name, got, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CH*DATA_W-1:0] rand_vec();
    logic [CH*DATA_W-1:0] d;
    for (int c = 0; c < int'(CH); c++) begin
      d[c*DATA_W +: DATA_W] = ($urandom_range(1) == 0) ? $urandom() :
                              DATA_W'($signed(8'($urandom())));
    end
    return d;
  endfunction

  task automatic run_frame(input int len, input bit keep);
    keep_kernel = keep;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sample(rand_vec(), (i == len - 1));
    end
    wait_done("frame_done");
    check("frame_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [CH*DATA_W-1:0] d;
    logic [K*DATA_W-1:0]  t;
    bit                   keep;

    reset       = 1'b1;
    ker_valid   = 1'b0;
    ker_data    = '0;
    keep_kernel = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ker_ready", ker_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ker_ready", ker_ready, 1);
    check("post_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;

    // Taps {1,2,3,4}; ch0 = 1..6, other channels scaled/negated copies.
    load_kernel({32'd4, 32'd3, 32'd2, 32'd1});
    @(negedge clk);
    check("fill_ker_ready", ker_ready, 0);
    check("fill_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    keep_kernel = 1'b1;
    for (int x = 1; x <= 6; x++) begin
      for (int c = 0; c < int'(CH); c++) d[c*DATA_W +: DATA_W] = DATA_W'(x * (c + 1) * ((c == 3) ? -1 : 1));
      send_sample(d, (x == 6));
      if (x == 4) begin
        @(negedge clk);
        check("latency_not_yet", out_valid, 0);
        @(negedge clk);
        check("latency_t_plus_2", out_valid, 1);
        check("first_ch0", out_data[ACC_W-1:0], 20);
        @(posedge clk);
        #1;
      end
    end
    wait_done("t1_done");
    check("t1_queue_empty", exp_q.size(), 0);

    // Backpressure: out_ready low for 3 cycles mid-stream.
    keep_kernel = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send_sample(rand_vec(), (i == 9));
      begin
        repeat (6) @(posedge clk);
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join
    wait_done("t2_done");
    check("t2_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("t2_reload_ker_ready", ker_ready, 1);
    @(posedge clk);
    #1;

    // Signed: taps {-1,0,0,0}; distinct per-channel data including -2^31.
    t = '0;
    t[DATA_W-1:0] = '1;
    load_kernel(t);
    keep_kernel = 1'b1;
    for (int i = 0; i < 3; i++) send_sample(rand_vec(), 1'b0);
    d = {32'h8000_0000, -32'sd123456, 32'sd17, -32'sd5};
    send_sample(d, 1'b0);
    d = {32'h7FFF_FFFF, 32'sd9, -32'sd1, 32'sd40};
    send_sample(d, 1'b1);
    wait_done("t3_done");

    // Short frames: keep taps, then request reload.
    keep_kernel = 1'b1;
    send_sample(rand_vec(), 1'b0);
    send_sample(rand_vec(), 1'b1);
    wait_done("t4_keep_done");
    @(negedge clk);
    check("t4_keep_ker_ready", ker_ready, 0);
    check("t4_keep_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    keep_kernel = 1'b0;
    send_sample(rand_vec(), 1'b0);
    send_sample(rand_vec(), 1'b1);
    wait_done("t4_reload_done");
    @(negedge clk);
    check("t4_reload_ker_ready", ker_ready, 1);
    check("t4_reload_in_ready", in_ready, 0);
    @(posedge clk);
    #1;

    // Overflow: all taps and samples at max positive.
    load_kernel({K{32'h7FFF_FFFF}});
    keep_kernel = 1'b1;
    for (int i = 0; i < 4; i++) send_sample({CH{32'h7FFF_FFFF}}, (i == 3));
    wait_done("t6_done");

    // Randomized frames with random throttling and occasional reloads.
    rdy_mode = 1;
    for (int f = 0; f < 14; f++) begin
      keep = ($urandom_range(2) != 0);
      run_frame($urandom_range(1, 12), keep);
      if (!keep) begin
        for (int j = 0; j < int'(K); j++) t[j*DATA_W +: DATA_W] = $urandom();
        load_kernel(t);
      end
    end
    rdy_mode = 0;

    // Reset mid-frame with a stalled result in flight.
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) send_sample(rand_vec(), 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    hist_q.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_ker_ready", ker_ready, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("midrst_release_ker_ready", ker_ready, 1);
    @(posedge clk);
    #1;
    load_kernel({32'd1, -32'sd2, 32'd3, 32'd5});
    run_frame(8, 1'b1);

    check("done_count", seen_done, exp_done);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
